alu_req_arbiter: RTL
====================

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameters SHALL be:
- NREQ, default 4: number of requesters.
- DATA_W, default 32: operand and result width.
- OP_W, default 4: opcode width.
- TIMEOUT_CYC, default 255: watchdog limit in cycles.
REQ-002 Ports SHALL be, clock and reset first:
- ACLK in 1: the one clock.
- ARESET in 1: synchronous, active-high reset.
- req_valid in NREQ: per-requester request valid.
- req_ready out NREQ: per-requester accept.
- req_opa in NREQ*DATA_W: operand A; requester k occupies slice k.
- req_opb in NREQ*DATA_W: operand B.
- req_op in NREQ*OP_W: opcode.
- alu_start out 1: single-cycle issue pulse to the ALU.
- alu_opa, alu_opb out DATA_W each: operands to the ALU.
- alu_op out OP_W: opcode to the ALU.
- alu_done in 1: ALU completion strobe.
- alu_result in DATA_W: ALU result.
- rsp_valid out 1: response valid.
- rsp_ready in 1: response accept.
- rsp_id out clog2(NREQ): index of the owning requester.
- rsp_data out DATA_W: result returned to the requester.
- rsp_err out 1: timeout flag.

Function
REQ-003 The block SHALL share one ALU between NREQ requesters through FSM states IDLE, ISSUE, WAIT and RESP.
REQ-004 In IDLE with any req_valid set:
- Grant the first valid requester at or after rr_ptr, searching with wrap-around.
- Assert req_ready for the granted requester only, combinationally in the same cycle.
- Capture its opa, opb and op.
- Set rr_ptr to (grant+1) mod NREQ.
- Move to ISSUE.
REQ-005 req_ready SHALL be 0 in every state other than IDLE, and 0 in IDLE when no req_valid is set.
REQ-006 ISSUE SHALL:
- Assert alu_start for exactly one cycle.
- Drive alu_opa, alu_opb and alu_op from the captured values; these hold stable until the next grant.
- Move to WAIT.
REQ-007 WAIT SHALL move to RESP on the first cycle alu_done=1, registering alu_result into rsp_data and setting rsp_err=0.
REQ-008 alu_done SHALL be ignored outside WAIT, including alu_done asserted in the ISSUE cycle.
REQ-009 In RESP:
- Hold rsp_valid=1 with rsp_id, rsp_data and rsp_err stable until rsp_ready=1.
- Then return to IDLE.
- No new grant is made in the handshake cycle; the earliest next grant is the following cycle.
REQ-010 Minimum latency SHALL be: request accepted at cycle T, alu_start at T+1, alu_done sampled at T+2 at the earliest, rsp_valid at T+3.
REQ-011 Only one operation SHALL be in flight at a time.
REQ-012 A requester dropping req_valid before it is granted SHALL lose its slot with no side effect.

Reset
REQ-013 With ARESET=1 on a rising ACLK edge, the block SHALL:
- Return to IDLE.
- Set rr_ptr=0.
- Drive req_ready, alu_start, rsp_valid and rsp_err to 0.
- Drive alu_opa, alu_opb, alu_op, rsp_id and rsp_data to 0.
- Clear the watchdog counter.
REQ-014 Reset during ISSUE, WAIT or RESP SHALL drop the in-flight operation with no response issued; a late alu_done after reset SHALL be ignored.

Configuration
REQ-015 Macro ALU_ARB_TIMEOUT_EN defined SHALL enable a watchdog counter in WAIT:
- The counter clears on entry to WAIT.
- After TIMEOUT_CYC cycles without alu_done, move to RESP with rsp_err=1 and rsp_data=0.
- If alu_done and expiry coincide, alu_done wins with rsp_err=0.
REQ-016 Macro ALU_ARB_TIMEOUT_EN undefined SHALL:
- Omit the counter logic.
- Keep the rsp_err port, tied to 0.
- Let WAIT wait indefinitely.

Structure
REQ-017 Package alu_arb_pkg SHALL hold the FSM state enum, the OP_W default and the ALU opcode constants (OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3) shared with the ALU IP.
REQ-018 Round-robin selection SHALL live in the sub-module rr_arbiter, with inputs req and ptr and outputs gnt_valid and gnt_idx, purely combinational; the FSM, capture registers and watchdog stay in alu_req_arbiter.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single request: req 0 with opa=5, opb=3, op=OP_ADD; ALU returns 8 one cycle after start -> rsp_valid at T+3, rsp_id=0, rsp_data=8, rsp_err=0.
- Contention: all four valid in one cycle, rr_ptr=0 -> grants in order 0,1,2,3, then 0 again on the next all-valid round.
- Backpressure: rsp_ready held low 10 cycles -> rsp_valid, rsp_id and rsp_data stable throughout; req_ready=0 throughout; no second alu_start.
- Reset: ARESET pulsed mid-WAIT, then alu_done -> no rsp_valid, state IDLE, rr_ptr=0.
- Timeout: with ALU_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, alu_done never asserted -> rsp_valid 16 cycles after WAIT entry, rsp_err=1, rsp_data=0.
- Coincidence: alu_done and watchdog expiry in the same cycle -> rsp_err=0 and rsp_data equals alu_result.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU request arbiter and the ALU IP it feeds.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int OP_W_DEF = 4;

  localparam logic [OP_W_DEF-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W_DEF-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W_DEF-1:0] OP_AND = 4'd2;
  localparam logic [OP_W_DEF-1:0] OP_OR  = 4'd3;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap-around.
module rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset back to ptr so the nearest hit is written last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr) + i) % NREQ);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one multi-cycle ALU between NREQ requesters, one operation in flight.
// Define ALU_ARB_TIMEOUT_EN to add a WAIT-state watchdog that reports rsp_err.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DATA_W      = 32,
  parameter int OP_W        = OP_W_DEF,
  parameter int TIMEOUT_CYC = 255,
  localparam int IDX_W      = idx_width(NREQ)
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_opa,
  input  logic [NREQ*DATA_W-1:0] req_opb,
  input  logic [NREQ*OP_W-1:0]   req_op,
  output logic                   alu_start,
  output logic [DATA_W-1:0]      alu_opa,
  output logic [DATA_W-1:0]      alu_opb,
  output logic [OP_W-1:0]        alu_op,
  input  logic                   alu_done,
  input  logic [DATA_W-1:0]      alu_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDX_W-1:0]       rsp_id,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err
);

  state_e              state_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [IDX_W-1:0]    rr_ptr_d;
  logic [DATA_W-1:0]   opa_q;
  logic [DATA_W-1:0]   opb_q;
  logic [OP_W-1:0]     op_q;
  logic                alu_start_q;
  logic                rsp_valid_q;
  logic [IDX_W-1:0]    rsp_id_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                gnt_valid;
  logic [IDX_W-1:0]    gnt_idx;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int               WDOG_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

  logic [WDOG_W-1:0] wdog_q;
  logic              rsp_err_q;
  logic              wdog_expired;

  assign wdog_expired = (wdog_q == WDOG_LAST);
  assign rsp_err      = rsp_err_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign rsp_err = 1'b0;
`endif

  // The accept is combinational so the requester sees it in the cycle it is chosen.
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && gnt_valid) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      op_q        <= '0;
      alu_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      wdog_q      <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            opa_q       <= req_opa[gnt_idx*DATA_W +: DATA_W];
            opb_q       <= req_opb[gnt_idx*DATA_W +: DATA_W];
            op_q        <= req_op[gnt_idx*OP_W +: OP_W];
            rsp_id_q    <= gnt_idx;
            rr_ptr_q    <= rr_ptr_d;
            alu_start_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          alu_start_q <= 1'b0;
          state_q     <= ST_WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
          wdog_q      <= '0;
`endif
        end
        // A real completion takes priority over a watchdog expiry in the same cycle.
        ST_WAIT: begin
          if (alu_done) begin
            rsp_data_q  <= alu_result;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
`ifdef ALU_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
          end
`ifdef ALU_ARB_TIMEOUT_EN
          else if (wdog_expired) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_start = alu_start_q;
  assign alu_opa   = opa_q;
  assign alu_opb   = opb_q;
  assign alu_op    = op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule
